// File: rtl/gato_pkg.sv
// Shared definitions for the tic-tac-toe board checker: cell codes,
// controller states, the winning-line table and small lookup helpers.
package gato_pkg;

    localparam int CELLS      = 9;
    localparam int SCAN_LINES = 8;

    // Two-bit cell codes as they appear on the board bus.
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;
    localparam logic [1:0] CELL_BAD   = 2'b11;

    localparam logic [3:0] MOVE_CNT_MAX = 4'd9;
    localparam logic [2:0] LAST_LINE    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WRITE  = 2'b01,
        ST_SCAN   = 2'b10,
        ST_REPORT = 2'b11
    } state_e;

    // Each entry packs three cell indices {a, b, c}; a sits in [11:8].
    // Scan order: three rows, three columns, then the two diagonals.
    localparam logic [11:0] LINE_TABLE [0:SCAN_LINES-1] = '{
        {4'd0, 4'd1, 4'd2},
        {4'd3, 4'd4, 4'd5},
        {4'd6, 4'd7, 4'd8},
        {4'd0, 4'd3, 4'd6},
        {4'd1, 4'd4, 4'd7},
        {4'd2, 4'd5, 4'd8},
        {4'd0, 4'd4, 4'd8},
        {4'd2, 4'd4, 4'd6}
    };

    // Read one cell; indices past the board read as the unused code so
    // they can never look empty.
    function automatic logic [1:0] cell_at(input logic [17:0] board,
                                           input logic [3:0]  pos);
        logic [1:0] code;
        case (pos)
            4'd0:    code = board[1:0];
            4'd1:    code = board[3:2];
            4'd2:    code = board[5:4];
            4'd3:    code = board[7:6];
            4'd4:    code = board[9:8];
            4'd5:    code = board[11:10];
            4'd6:    code = board[13:12];
            4'd7:    code = board[15:14];
            4'd8:    code = board[17:16];
            default: code = CELL_BAD;
        endcase
        return code;
    endfunction

    // Code of the other player; anything else maps to the unused code,
    // which never appears on the board and so never matches a line.
    function automatic logic [1:0] opponent_of(input logic [1:0] owner);
        logic [1:0] opp;
        case (owner)
            CELL_P1: opp = CELL_P2;
            CELL_P2: opp = CELL_P1;
            default: opp = CELL_BAD;
        endcase
        return opp;
    endfunction

    // Move counter step, saturating at a full board.
    function automatic logic [3:0] move_cnt_next(input logic [3:0] cnt);
        logic [3:0] nxt;
        if (cnt >= MOVE_CNT_MAX) begin
            nxt = MOVE_CNT_MAX;
        end else begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gato_line_eval.sv
// Evaluates one winning line of the board: whether all three cells belong
// to the moving player, and whether all three belong to the opponent.
module gato_line_eval
    import gato_pkg::*;
(
    input  logic [17:0] board_i,
    input  logic [2:0]  line_idx_i,
    input  logic [1:0]  owner_i,
    output logic        own_hit_o,
    output logic        opp_hit_o
);

    logic [11:0] line_s;
    logic [1:0]  cell_a_s;
    logic [1:0]  cell_b_s;
    logic [1:0]  cell_c_s;
    logic [1:0]  opp_code_s;

    // Look up the three cells of the selected line and compare them.
    always_comb begin
        line_s     = LINE_TABLE[line_idx_i];
        cell_a_s   = cell_at(board_i, line_s[11:8]);
        cell_b_s   = cell_at(board_i, line_s[7:4]);
        cell_c_s   = cell_at(board_i, line_s[3:0]);
        opp_code_s = opponent_of(owner_i);
        own_hit_o  = (cell_a_s == owner_i) && (cell_b_s == owner_i) &&
                     (cell_c_s == owner_i);
        opp_hit_o  = (cell_a_s == opp_code_s) && (cell_b_s == opp_code_s) &&
                     (cell_c_s == opp_code_s);
    end

endmodule

// File: rtl/gato_board_checker.sv
// Board keeper for the tic-tac-toe game: validates move requests, writes
// the cell, scans the eight lines one per cycle and then pulses the
// mover's move-made strobe with the status flags already settled.
module gato_board_checker
    import gato_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        move_valid,
    input  logic [3:0]  move_pos,
    input  logic        turno_p1,
    input  logic        turno_p2,
    input  logic        verifica_status,
    output logic        p1_mm,
    output logic        p2_mm,
    output logic        p1_win,
    output logic        p1_loss,
    output logic        p1_tie,
    output logic        p2_win,
    output logic        p2_loss,
    output logic        p2_tie,
    output logic        move_reject,
    output logic        busy,
    output logic [17:0] board
);

    state_e      state_q,     state_d;
    logic [17:0] board_q,     board_d;
    logic [3:0]  pos_q,       pos_d;
    logic [1:0]  owner_q,     owner_d;
    logic [3:0]  move_cnt_q,  move_cnt_d;
    logic [2:0]  line_idx_q,  line_idx_d;
    logic        own_acc_q,   own_acc_d;
    logic        opp_acc_q,   opp_acc_d;
    logic        game_over_q, game_over_d;
    logic        p1_mm_q,     p1_mm_d;
    logic        p2_mm_q,     p2_mm_d;
    logic        reject_q,    reject_d;
    logic        p1_win_q,    p1_win_d;
    logic        p1_loss_q,   p1_loss_d;
    logic        p1_tie_q,    p1_tie_d;
    logic        p2_win_q,    p2_win_d;
    logic        p2_loss_q,   p2_loss_d;
    logic        p2_tie_q,    p2_tie_d;

    logic        own_hit_s;
    logic        opp_hit_s;
    logic        own_now_s;
    logic        opp_now_s;
    logic        tie_now_s;
    logic        accept_s;
    logic        unused_verifica_s;

    // The status-check request from the game FSM carries no behaviour here.
    assign unused_verifica_s = verifica_status;

    gato_line_eval u_line_eval (
        .board_i    (board_q),
        .line_idx_i (line_idx_q),
        .owner_i    (owner_q),
        .own_hit_o  (own_hit_s),
        .opp_hit_o  (opp_hit_s)
    );

    // Request legality: on the board, empty cell, unambiguous turn, game live.
    always_comb begin
        accept_s = (move_pos <= 4'd8) &&
                   (cell_at(board_q, move_pos) == CELL_EMPTY) &&
                   (turno_p1 ^ turno_p2) &&
                   !game_over_q;
    end

    // Running line results including the line under evaluation this cycle.
    always_comb begin
        own_now_s = own_acc_q | own_hit_s;
        opp_now_s = opp_acc_q | opp_hit_s;
        tie_now_s = (move_cnt_q == MOVE_CNT_MAX) && !own_now_s && !opp_now_s;
    end

    // Next-state and next-output logic for the move controller.
    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        pos_d       = pos_q;
        owner_d     = owner_q;
        move_cnt_d  = move_cnt_q;
        line_idx_d  = line_idx_q;
        own_acc_d   = own_acc_q;
        opp_acc_d   = opp_acc_q;
        game_over_d = game_over_q;
        p1_mm_d     = 1'b0;
        p2_mm_d     = 1'b0;
        reject_d    = 1'b0;
        p1_win_d    = p1_win_q;
        p1_loss_d   = p1_loss_q;
        p1_tie_d    = p1_tie_q;
        p2_win_d    = p2_win_q;
        p2_loss_d   = p2_loss_q;
        p2_tie_d    = p2_tie_q;

        case (state_q)
            ST_IDLE: begin
                if (move_valid && accept_s) begin
                    pos_d   = move_pos;
                    owner_d = turno_p1 ? CELL_P1 : CELL_P2;
                    state_d = ST_WRITE;
                end else if (move_valid) begin
                    reject_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WRITE: begin
                for (int k = 0; k < CELLS; k++) begin
                    if (pos_q == 4'(k)) begin
                        board_d[2*k +: 2] = owner_q;
                    end else begin
                        board_d[2*k +: 2] = board_q[2*k +: 2];
                    end
                end
                move_cnt_d = move_cnt_next(move_cnt_q);
                line_idx_d = 3'd0;
                own_acc_d  = 1'b0;
                opp_acc_d  = 1'b0;
                state_d    = ST_SCAN;
            end

            ST_SCAN: begin
                own_acc_d = own_now_s;
                opp_acc_d = opp_now_s;
                if (line_idx_q == LAST_LINE) begin
                    // Settle the mover's flags now so they lead the strobe.
                    if (owner_q == CELL_P1) begin
                        p1_win_d  = own_now_s;
                        p1_loss_d = opp_now_s;
                        p1_tie_d  = tie_now_s;
                        p2_win_d  = 1'b0;
                        p2_loss_d = 1'b0;
                        p2_tie_d  = 1'b0;
                    end else begin
                        p1_win_d  = 1'b0;
                        p1_loss_d = 1'b0;
                        p1_tie_d  = 1'b0;
                        p2_win_d  = own_now_s;
                        p2_loss_d = opp_now_s;
                        p2_tie_d  = tie_now_s;
                    end
                    game_over_d = game_over_q | own_now_s | tie_now_s;
                    line_idx_d  = 3'd0;
                    state_d     = ST_REPORT;
                end else begin
                    line_idx_d = line_idx_q + 3'd1;
                end
            end

            ST_REPORT: begin
                if (owner_q == CELL_P1) begin
                    p1_mm_d = 1'b1;
                end else begin
                    p2_mm_d = 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any move in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            board_q     <= 18'd0;
            pos_q       <= 4'd0;
            owner_q     <= CELL_EMPTY;
            move_cnt_q  <= 4'd0;
            line_idx_q  <= 3'd0;
            own_acc_q   <= 1'b0;
            opp_acc_q   <= 1'b0;
            game_over_q <= 1'b0;
            p1_mm_q     <= 1'b0;
            p2_mm_q     <= 1'b0;
            reject_q    <= 1'b0;
            p1_win_q    <= 1'b0;
            p1_loss_q   <= 1'b0;
            p1_tie_q    <= 1'b0;
            p2_win_q    <= 1'b0;
            p2_loss_q   <= 1'b0;
            p2_tie_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            pos_q       <= pos_d;
            owner_q     <= owner_d;
            move_cnt_q  <= move_cnt_d;
            line_idx_q  <= line_idx_d;
            own_acc_q   <= own_acc_d;
            opp_acc_q   <= opp_acc_d;
            game_over_q <= game_over_d;
            p1_mm_q     <= p1_mm_d;
            p2_mm_q     <= p2_mm_d;
            reject_q    <= reject_d;
            p1_win_q    <= p1_win_d;
            p1_loss_q   <= p1_loss_d;
            p1_tie_q    <= p1_tie_d;
            p2_win_q    <= p2_win_d;
            p2_loss_q   <= p2_loss_d;
            p2_tie_q    <= p2_tie_d;
        end
    end

    assign p1_mm       = p1_mm_q;
    assign p2_mm       = p2_mm_q;
    assign p1_win      = p1_win_q;
    assign p1_loss     = p1_loss_q;
    assign p1_tie      = p1_tie_q;
    assign p2_win      = p2_win_q;
    assign p2_loss     = p2_loss_q;
    assign p2_tie      = p2_tie_q;
    assign move_reject = reject_q;
    assign busy        = (state_q != ST_IDLE);
    assign board       = board_q;

endmodule

// File: tb/tb_gato_board_checker.sv
// Self-checking bench for gato_board_checker: directed scenarios followed by
// random games, all compared against a plain tic-tac-toe reference model.
module tb_gato_board_checker;

    logic        clk;
    logic        reset;
    logic        move_valid;
    logic [3:0]  move_pos;
    logic        turno_p1;
    logic        turno_p2;
    logic        verifica_status;
    logic        p1_mm, p2_mm;
    logic        p1_win, p1_loss, p1_tie;
    logic        p2_win, p2_loss, p2_tie;
    logic        move_reject;
    logic        busy;
    logic [17:0] board;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain board of player numbers (0 empty, 1, 2).
    int         m_cells [9];
    int         m_moves;
    bit         m_over;
    logic [5:0] m_flags;   // {p1 win, loss, tie, p2 win, loss, tie}

    gato_board_checker dut (
        .clk             (clk),
        .reset           (reset),
        .move_valid      (move_valid),
        .move_pos        (move_pos),
        .turno_p1        (turno_p1),
        .turno_p2        (turno_p2),
        .verifica_status (verifica_status),
        .p1_mm           (p1_mm),
        .p2_mm           (p2_mm),
        .p1_win          (p1_win),
        .p1_loss         (p1_loss),
        .p1_tie          (p1_tie),
        .p2_win          (p2_win),
        .p2_loss         (p2_loss),
        .p2_tie          (p2_tie),
        .move_reject     (move_reject),
        .busy            (busy),
        .board           (board)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] dut_flags();
        return {p1_win, p1_loss, p1_tie, p2_win, p2_loss, p2_tie};
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] b = 18'd0;
        for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'(m_cells[k]);
        return b;
    endfunction

    // True when player p owns any full row, column or diagonal.
    function automatic bit model_line(input int p);
        bit hit = 0;
        for (int r = 0; r < 3; r++)
            if (m_cells[3*r] == p && m_cells[3*r+1] == p && m_cells[3*r+2] == p) hit = 1;
        for (int c = 0; c < 3; c++)
            if (m_cells[c] == p && m_cells[c+3] == p && m_cells[c+6] == p) hit = 1;
        if (m_cells[0] == p && m_cells[4] == p && m_cells[8] == p) hit = 1;
        if (m_cells[2] == p && m_cells[4] == p && m_cells[6] == p) hit = 1;
        return hit;
    endfunction

    function automatic bit model_accepts(input int pos, input bit t1, input bit t2);
        if (pos > 8) return 0;
        if (m_cells[pos] != 0) return 0;
        if (t1 == t2) return 0;
        if (m_over) return 0;
        return 1;
    endfunction

    task automatic model_apply(input int pos, input int p);
        bit own, opp, tie;
        m_cells[pos] = p;
        if (m_moves < 9) m_moves++;
        own = model_line(p);
        opp = model_line(3 - p);
        tie = (m_moves == 9) && !own && !opp;
        if (p == 1) m_flags = {own, opp, tie, 3'b000};
        else        m_flags = {3'b000, own, opp, tie};
        if (own || tie) m_over = 1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 9; k++) m_cells[k] = 0;
        m_moves = 0;
        m_over  = 0;
        m_flags = 6'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rst_board", 32'(board), 32'd0);
        check_val("rst_outs", {20'd0, p1_mm, p2_mm, move_reject, busy, 2'b00, dut_flags()}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Issue one request; follow it to the strobe or the reject pulse.
    task automatic send(input int pos, input bit t1, input bit t2, input bit inject);
        bit   acc;
        int   p, mm_cyc, mm_cnt;
        logic seen_rej;
        logic [1:0] mm_at;
        logic [5:0] flags_at;
        acc = model_accepts(pos, t1, t2);
        p   = t1 ? 1 : 2;
        @(negedge clk);
        move_valid = 1'b1;
        move_pos   = 4'(pos);
        turno_p1   = t1;
        turno_p2   = t2;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        if (acc) begin
            model_apply(pos, p);
            check_val("acc_busy", 32'(busy), 32'd1);
            check_val("acc_norej", 32'(move_reject), 32'd0);
            mm_cyc = 0; mm_cnt = 0; seen_rej = 1'b0;
            mm_at = 2'b00; flags_at = 6'd0;
            for (int c = 1; c <= 12; c++) begin
                @(posedge clk);
                #1;
                if (inject && c == 3) begin
                    move_valid = 1'b1;
                    move_pos   = 4'($urandom_range(0, 8));
                    turno_p1   = ~t1;
                    turno_p2   = ~t2;
                end else begin
                    move_valid = 1'b0;
                end
                if (p1_mm || p2_mm) begin
                    mm_cnt++;
                    if (mm_cyc == 0) begin
                        mm_cyc   = c;
                        mm_at    = {p1_mm, p2_mm};
                        flags_at = dut_flags();
                    end
                end
                if (move_reject) seen_rej = 1'b1;
            end
            check_val("mm_latency", 32'(mm_cyc), 32'd10);
            check_val("mm_pulses", 32'(mm_cnt), 32'd1);
            check_val("mm_owner", 32'(mm_at), (p == 1) ? 32'd2 : 32'd1);
            check_val("flags", 32'(flags_at), 32'(m_flags));
            check_val("busy_norej", 32'(seen_rej), 32'd0);
            check_val("board", 32'(board), 32'(model_board()));
            check_val("idle_after", 32'(busy), 32'd0);
        end else begin
            check_val("rej_pulse", 32'(move_reject), 32'd1);
            check_val("rej_busy", 32'(busy), 32'd0);
            check_val("rej_board", 32'(board), 32'(model_board()));
            check_val("rej_flags", 32'(dut_flags()), 32'(m_flags));
            @(posedge clk);
            #1;
            check_val("rej_once", {30'd0, move_reject, p1_mm | p2_mm}, 32'd0);
        end
    endtask

    initial begin
        int turn, pos, r, empties[$];
        bit t1, t2;
        reset = 1'b1;
        move_valid = 1'b0; move_pos = 4'd0;
        turno_p1 = 1'b0; turno_p2 = 1'b0; verifica_status = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First move in the centre.
        do_reset();
        send(4, 1, 0, 1);
        check_val("centre_board", 32'(board), 32'h00100);

        // Occupied cell, off-board index, ambiguous turn.
        do_reset();
        send(0, 1, 0, 0);
        send(0, 0, 1, 0);
        send(9, 0, 1, 0);
        send(5, 1, 1, 0);
        send(5, 0, 0, 0);

        // P1 wins the top row; the game is then closed.
        do_reset();
        send(0, 1, 0, 0); send(3, 0, 1, 0);
        send(1, 1, 0, 0); send(4, 0, 1, 0);
        send(2, 1, 0, 0);
        check_val("row_win", 32'(p1_win), 32'd1);
        send(5, 0, 1, 0);

        // Full board without a line.
        do_reset();
        send(0, 1, 0, 0); send(1, 0, 1, 0); send(2, 1, 0, 0);
        send(4, 0, 1, 0); send(3, 1, 0, 0); send(5, 0, 1, 0);
        send(7, 1, 0, 0); send(6, 0, 1, 0); send(8, 1, 0, 0);
        check_val("tie_flag", {30'd0, p1_tie, p1_win}, 32'd2);

        // Reset while the line scan is running.
        do_reset();
        @(negedge clk);
        move_valid = 1'b1; move_pos = 4'd6; turno_p1 = 1'b1; turno_p2 = 1'b0;
        @(posedge clk);
        #1 move_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("midrst_board", 32'(board), 32'd0);
        check_val("midrst_outs", {26'd0, busy, p1_mm, p2_mm, move_reject, 2'b00}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        r = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (p1_mm || p2_mm || busy) r++;
        end
        check_val("midrst_quiet", 32'(r), 32'd0);
        send(6, 0, 1, 0);

        // Random games.
        for (int g = 0; g < 30; g++) begin
            do_reset();
            turn = 1;
            for (int m = 0; m < 12; m++) begin
                empties.delete();
                for (int k = 0; k < 9; k++) if (m_cells[k] == 0) empties.push_back(k);
                if (empties.size() > 0 && $urandom_range(0, 9) < 8)
                    pos = empties[$urandom_range(0, empties.size() - 1)];
                else
                    pos = $urandom_range(0, 10);
                r = $urandom_range(0, 9);
                if (r == 0)      begin t1 = 1; t2 = 1; end
                else if (r == 1) begin t1 = 0; t2 = 0; end
                else             begin t1 = (turn == 1); t2 = (turn == 2); end
                if (model_accepts(pos, t1, t2)) turn = 3 - turn;
                send(pos, t1, t2, ($urandom_range(0, 3) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gato_board_checker.md
Name: gato_board_checker

Overview:
Upstream companion of the tic-tac-toe game FSM; it is the "other state machine" that drives p1_mm/p2_mm and the six status flags.
- Holds the 3x3 board and validates each move request against the current turn.
- Writes the cell, scans all 8 lines sequentially, then pulses the move-made strobe with the status flags already valid.

Parameters:
SCAN_LINES, 8, number of winning lines scanned (fixed by 3x3 board; not for override)
CELLS, 9, board cell count

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears board, flags and FSM
move_valid  input  1  one-cycle request to place a mark at move_pos
move_pos  input  4  cell index 0..8, row-major, 0 = top-left
turno_p1  input  1  from game FSM: P1 to move
turno_p2  input  1  from game FSM: P2 to move
verifica_status  input  1  from game FSM; informational only, no effect on behaviour
p1_mm  output  1  one-cycle pulse: P1 move committed, flags valid
p2_mm  output  1  one-cycle pulse: P2 move committed, flags valid
p1_win, p1_loss, p1_tie  output  1 each  status after a P1 move
p2_win, p2_loss, p2_tie  output  1 each  status after a P2 move
move_reject  output  1  one-cycle pulse: request refused
busy  output  1  high whenever FSM not in IDLE
board  output  18  cell k at bits [2k+1:2k]; 00 empty, 01 P1, 10 P2, 11 unused

Behaviour:
- Reset (async, active-high): state IDLE; board=0; move counter=0; line index=0; game_over=0; all outputs 0.
- FSM states: IDLE, WRITE, SCAN, REPORT.
- IDLE, move_valid=1, accepted only if all hold: move_pos<=8; target cell==00; exactly one of turno_p1/turno_p2 high; game_over==0.
  - On accept: latch pos and owner (P1 if turno_p1); go to WRITE.
  - Otherwise: move_reject=1 the next cycle; stay IDLE; board unchanged.
- WRITE, 1 cycle: write the owner code into the cell; increment the move counter (0..9, saturating at 9).
- SCAN, 8 cycles, line index 0..7; one line per cycle.
  - Order: rows 0-1-2, 3-4-5, 6-7-8; columns 0-3-6, 1-4-7, 2-5-8; diagonals 0-4-8, 2-4-6.
  - Accumulate own_line (all three cells == owner) and opp_line (all three == opponent code).
- Leaving SCAN (edge into REPORT), the flags of the moving player are registered:
  - win = own_line.
  - loss = opp_line.
  - tie = (counter==9) & ~own_line & ~opp_line.
  - The other player's three flags are cleared.
  - game_over set if win or tie.
- REPORT, 1 cycle: owner's p*_mm=1; return to IDLE.
- Latency: acceptance edge E; p*_mm is high in the cycle beginning at E+10 clock edges. The game FSM therefore sees flags and mm together.
- Flags hold until the next accepted move reaches REPORT, or until reset.
- p1_mm/p2_mm never high together, never high for more than 1 cycle.
- move_valid while busy: ignored, no reject pulse.
- After game_over, every request is rejected until reset.
- Reset mid-operation (any state): immediate return to reset values; partially processed move discarded; no mm pulse.
- move_valid and reset together: reset wins.

Decomposition:
- Package gato_pkg:
  - cell encodings (CELL_EMPTY, CELL_P1, CELL_P2);
  - state enum;
  - constant table of the 8 lines as three 4-bit cell indices each.
- Sub-module gato_line_eval (combinational): takes board, line index and owner code; returns own_hit and opp_hit for that line.

Test Plan:
- Reset, then turno_p1=1, move_valid with move_pos=4 -> board=18'h00100; p1_mm pulse 10 cycles after accept; all six flags 0.
- P1 at 0, then P2 requests 0 -> move_reject pulse next cycle; board unchanged; no p2_mm.
- Request with move_pos=9, and separately with turno_p1=turno_p2=1 -> move_reject pulse each time; busy stays 0.
- P1 at 0,1,2 with P2 at 3,4 interleaved -> on third P1 move, p1_win=1 coincident with p1_mm; further requests rejected.
- Full board, no line (P1:0,2,3,7,8 / P2:1,4,5,6) -> ninth move gives p1_tie=1 with p1_mm; p1_win=0.
- Reset asserted during SCAN -> outputs 0 immediately; board cleared; no mm pulse; move_valid during busy produces neither reject nor a second move.
